// File: rtl/aes_inv.sv
// Iterative AES inverse cipher: one decryption round per eph1 cycle using the shared expanded-key array.
// Optional macro AES_INV_MULTIKEY_EN enables AES-192/256 via key_len; without it Nr is fixed at 10.
module aes_inv (
   input  logic               eph1,
   input  logic               reset,
   input  logic               start,
   input  logic               ready,
   input  logic [1:0]         key_len,
   input  logic [127:0]       cipher_text,
   input  logic [15:1][127:0] key_words,
   output logic               busy,
   output logic               done,
   output logic [127:0]       plain_out
);

   // Inverse S-box, entry 0 in the top byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a   [4];
      logic [7:0] m9  [4];
      logic [7:0] mb  [4];
      logic [7:0] md  [4];
      logic [7:0] me  [4];
      logic [7:0] x2, x4, x8;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         x2    = xt(a[r]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[r] = x8 ^ a[r];
         mb[r] = x8 ^ x2 ^ a[r];
         md[r] = x8 ^ x4 ^ a[r];
         me[r] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic [127:0] state_q, state_d;
   logic [127:0] plain_q, plain_d;
   logic [3:0]   kidx_q, kidx_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [127:0] acc_key;
   logic [3:0]   kidx_init;
   logic [127:0] isr, sb, ark, imc, round_out;

`ifdef AES_INV_MULTIKEY_EN
   // Accept key is round key Nr; kidx then walks from 16-Nr up to 15.
   always_comb begin
      acc_key   = key_words[5];
      kidx_init = 4'd6;
      case (key_len)
         2'b01: begin acc_key = key_words[3]; kidx_init = 4'd4; end
         2'b10: begin acc_key = key_words[1]; kidx_init = 4'd2; end
         default: ;
      endcase
   end
`else
   logic unused_key_len;
   assign unused_key_len = ^key_len;
   assign acc_key        = key_words[5];
   assign kidx_init      = 4'd6;
`endif

   always_comb begin
      isr = '0;
      sb  = '0;
      imc = '0;
      // Row r of the column-major state rotates right by r.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            isr[8*(15-4*c-r) +: 8] = state_q[8*(15-4*((c-r+4)%4)-r) +: 8];
      for (int i = 0; i < 16; i++)
         sb[8*i +: 8] = INV_SBOX[8*(255-int'(isr[8*i +: 8])) +: 8];
      ark = sb ^ key_words[kidx_q];
      for (int c = 0; c < 4; c++)
         imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
      round_out = (kidx_q == 4'd15) ? ark : imc;
   end

   always_comb begin
      state_d = state_q;
      plain_d = plain_q;
      kidx_d  = kidx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (busy_q) begin
         state_d = round_out;
         if (kidx_q == 4'd15) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            plain_d = round_out;
         end else begin
            kidx_d = kidx_q + 4'd1;
         end
      end else if (start && ready) begin
         state_d = cipher_text ^ acc_key;
         kidx_d  = kidx_init;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge eph1) begin
      if (reset) begin
         state_q <= '0;
         plain_q <= '0;
         kidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         plain_q <= plain_d;
         kidx_q  <= kidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign plain_out = plain_q;

endmodule

// File: tb/tb_aes_inv.sv
// Directed bench for aes_inv: FIPS-197 vectors, reference-encrypted blocks, and handshake corner cases.
// Valid/ready: a block is accepted on a rising edge where start & ready & ~busy; done pulses one cycle with plain_out.
module tb_aes_inv;

   logic               eph1 = 1'b0;
   logic               reset;
   logic               start;
   logic               ready;
   logic [1:0]         key_len;
   logic [127:0]       cipher_text;
   logic [15:1][127:0] key_words;
   logic               busy;
   logic               done;
   logic [127:0]       plain_out;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic [7:0]         sbox_t [256];
   logic [15:1][127:0] kw128, kw192, kw256;

   typedef struct {
      int         key_sel;
      logic [1:0] klen;
      logic [127:0] ct;
      logic [127:0] pt;
      int         lat;
   } vec_t;
   vec_t vt [8];

   aes_inv dut (
      .eph1        (eph1),
      .reset       (reset),
      .start       (start),
      .ready       (ready),
      .key_len     (key_len),
      .cipher_text (cipher_text),
      .key_words   (key_words),
      .busy        (busy),
      .done        (done),
      .plain_out   (plain_out)
   );

   always #5 eph1 = ~eph1;

   // ---------------- reference model: forward AES from GF arithmetic ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [15:1][127:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]        w [60];
      logic [31:0]        t;
      logic [7:0]         rcon = 8'h01;
      logic [15:1][127:0] kw = '0;
      int                 nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k <= nr; k++) kw[15-k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      return kw;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [15:1][127:0] kw, input int nr);
      logic [127:0] s;
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      s = pt ^ kw[15];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++) begin
            if (rnd < nr) begin
               m[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               m[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               m[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) m[4*c+r] = t[4*c+r];
            end
         end
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m[i];
         s = s ^ kw[15-rnd];
      end
      return s;
   endfunction

   function automatic logic [15:1][127:0] kw_of(input int sel);
      return (sel == 1) ? kw192 : (sel == 2) ? kw256 : kw128;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- checking and drivers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at the negedge after the accept edge; returns edges until done is seen.
   task automatic wait_done(output int edges);
      edges = 0;
      do begin
         @(negedge eph1);
         edges++;
      end while (!done && edges < 40);
   endtask

   task automatic issue(input logic [15:1][127:0] kw, input logic [1:0] kl, input logic [127:0] ct);
      key_words   = kw;
      key_len     = kl;
      cipher_text = ct;
      start       = 1'b1;
      @(negedge eph1);
      start       = 1'b0;
      cipher_text = rnd128();
      key_len     = 2'($urandom_range(0, 3));
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      int edges;
      @(negedge eph1);
      issue(kw_of(v.key_sel), v.klen, v.ct);
      chk({nm, " busy"}, 128'(busy), 128'(1));
      wait_done(edges);
      chk({nm, " latency"}, 128'(edges), 128'(v.lat));
      chk({nm, " plain"}, plain_out, v.pt);
   endtask

   initial begin
      int         edges;
      logic       seen_done, seen_busy;
      logic [127:0] pb, pc, cb, cc;

      build_sbox();
      kw128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
      kw192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
      kw256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

      reset = 1'b1; start = 1'b0; ready = 1'b1; key_len = 2'b00;
      cipher_text = '0; key_words = kw128;
      repeat (3) @(negedge eph1);
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset done", 128'(done), 128'(0));
      chk("reset plain", plain_out, 128'h0);
      reset = 1'b0;

      vt[0] = '{0, 2'b00, CT_128, FIPS_PT, 10};
`ifdef AES_INV_MULTIKEY_EN
      vt[1] = '{1, 2'b01, CT_192, FIPS_PT, 12};
      vt[2] = '{2, 2'b10, CT_256, FIPS_PT, 14};
`else
      vt[1] = '{0, 2'b01, CT_128, FIPS_PT, 10};
      vt[2] = '{0, 2'b10, CT_128, FIPS_PT, 10};
`endif
      vt[3] = '{0, 2'b11, CT_128, FIPS_PT, 10};
      for (int i = 4; i < 8; i++) begin
         vt[i].pt = rnd128();
`ifdef AES_INV_MULTIKEY_EN
         vt[i].key_sel = i % 3;
         vt[i].klen    = 2'(i % 3);
         vt[i].lat     = 10 + 2 * (i % 3);
`else
         vt[i].key_sel = 0;
         vt[i].klen    = 2'($urandom_range(0, 3));
         vt[i].lat     = 10;
`endif
         vt[i].ct = aes_enc(vt[i].pt, kw_of(vt[i].key_sel), vt[i].lat);
      end
      for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

      // Back-to-back: second start in the done cycle of the first.
      pb = rnd128();
      cb = aes_enc(pb, kw128, 10);
      @(negedge eph1);
      issue(kw128, 2'b00, CT_128);
      wait_done(edges);
      chk("b2b first plain", plain_out, FIPS_PT);
      issue(kw128, 2'b00, cb);
      chk("b2b done cleared", 128'(done), 128'(0));
      chk("b2b busy", 128'(busy), 128'(1));
      chk("b2b first held", plain_out, FIPS_PT);
      wait_done(edges);
      chk("b2b latency", 128'(edges), 128'(10));
      chk("b2b second plain", plain_out, pb);

      // Starts while busy at edges 3 and 7 are dropped.
      pc = rnd128();
      cc = aes_enc(pc, kw128, 10);
      @(negedge eph1);
      issue(kw128, 2'b00, cc);
      edges = 0;
      do begin
         @(negedge eph1);
         edges++;
         start = (edges == 3 || edges == 7);
         cipher_text = rnd128();
      end while (!done && edges < 40);
      start = 1'b0;
      chk("ign latency", 128'(edges), 128'(10));
      chk("ign plain", plain_out, pc);

      // Start with ready low is dropped.
      ready = 1'b0;
      start = 1'b1;
      cipher_text = CT_128;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge eph1);
         if (i == 1) start = 1'b0;
         seen_done |= done;
         seen_busy |= busy;
      end
      ready = 1'b1;
      chk("notready no done", 128'(seen_done), 128'(0));
      chk("notready no busy", 128'(seen_busy), 128'(0));
      chk("notready plain held", plain_out, pc);

      // Reset at edge 5 of a decrypt, with a start in the same cycle.
      @(negedge eph1);
      issue(kw128, 2'b00, CT_128);
      for (int i = 1; i < 5; i++) @(negedge eph1);
      reset = 1'b1;
      start = 1'b1;
      cipher_text = CT_128;
      @(negedge eph1);
      reset = 1'b0;
      start = 1'b0;
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst done", 128'(done), 128'(0));
      chk("rst plain", plain_out, 128'h0);
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge eph1);
         seen_done |= done;
         seen_busy |= busy;
      end
      chk("rst no done", 128'(seen_done), 128'(0));
      chk("rst no busy", 128'(seen_busy), 128'(0));

      run_vec("post-reset", vt[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
